// File: rtl/secuenciador_jugada_pkg.sv
// Shared types, move codes and FSM states for the 2048 board sequencer.
package pkg_2048;

    typedef logic [11:0] celda_t;
    typedef celda_t linea_t [3:0];

    localparam logic [3:0] MOV_IZQ = 4'b0100;
    localparam logic [3:0] MOV_DER = 4'b0011;
    localparam logic [3:0] MOV_ARR = 4'b0101;
    localparam logic [3:0] MOV_ABA = 4'b0110;

    typedef enum logic [2:0] {
        INICIO0,
        INICIO1,
        IDLE,
        LINEA,
        NUEVA,
        EVAL,
        FIN
    } estado_t;

    function automatic logic mov_valido(input logic [3:0] mov);
        return mov inside {MOV_IZQ, MOV_DER, MOV_ARR, MOV_ABA};
    endfunction

    // Flat cell index {fila, columna} of line element j (element 0 = destination end).
    function automatic logic [3:0] celda_idx(input logic [3:0] mov, input logic [1:0] k,
                                             input logic [1:0] j);
        logic [1:0] inv;
        inv = 2'd3 - j;
        case (mov)
            MOV_DER: return {k, inv};
            MOV_ARR: return {j, k};
            MOV_ABA: return {inv, k};
            default: return {k, j};
        endcase
    endfunction

endpackage

// File: rtl/fusion_linea.sv
// Combinational slide-and-merge of one 4-tile line toward element 0.
module fusion_linea
    import pkg_2048::*;
(
    input  linea_t      linea_in,
    output linea_t      linea_out,
    output logic [12:0] puntos,
    output logic        difiere
);

    linea_t     comp;
    linea_t     merg;
    logic [1:0] n;
    logic [1:0] m;

    always_comb begin
        comp      = '{default: '0};
        merg      = '{default: '0};
        linea_out = '{default: '0};
        puntos    = '0;
        difiere   = 1'b0;
        n         = '0;
        m         = '0;

        for (int i = 0; i < 4; i++) begin
            if (linea_in[i] != '0) begin
                comp[n] = linea_in[i];
                n       = n + 2'd1;
            end
        end

        // Clearing the partner keeps a freshly merged tile from merging again.
        merg = comp;
        for (int i = 0; i < 3; i++) begin
            if (merg[i] != '0 && merg[i] == merg[i+1]) begin
                merg[i]   = {merg[i][10:0], 1'b0};
                merg[i+1] = '0;
                puntos    = puntos + 13'(merg[i]);
            end
        end

        for (int i = 0; i < 4; i++) begin
            if (merg[i] != '0) begin
                linea_out[m] = merg[i];
                m            = m + 2'd1;
            end
        end

        for (int i = 0; i < 4; i++) begin
            if (linea_out[i] != linea_in[i]) difiere = 1'b1;
        end
    end

endmodule

// File: rtl/secuenciador_jugada.sv
// 2048 board owner: sequences line passes, tile spawn and win/lose evaluation per move.
// Define PUNTAJE_EN to build the saturating score register; otherwise puntaje reads 0.
module secuenciador_jugada
    import pkg_2048::*;
#(
    parameter logic [15:0] LFSR_SEMILLA = 16'hACE1,
    parameter logic [11:0] VALOR_META   = 12'd2048
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              mov,
    input  logic                    mov_valid,
    output logic                    mov_ready,
    output logic [3:0][3:0][11:0]   matriz,
    output logic [15:0]             puntaje,
    output logic                    ganado,
    output logic                    perdido,
    output logic                    done,
    output logic                    cambio
);

    estado_t              estado_q, estado_d;
    logic [3:0]           mov_q, mov_d;
    logic [1:0]           k_q, k_d;
    logic [3:0][3:0][11:0] matriz_q, matriz_d;
    logic                 cambio_q, cambio_d;
    logic                 ganado_q, ganado_d;
    logic                 perdido_q, perdido_d;
    logic [15:0]          lfsr_q, lfsr_d;

    logic [3:0][3:0] idx_l;
    linea_t          linea_ent;
    linea_t          linea_sal;
    logic [12:0]     puntos;
    logic            difiere;

    logic            libre_enc;
    logic [3:0]      libre_idx;
    logic [3:0]      p;
    logic [11:0]     valor_nuevo;
    logic            lleno;
    logic            hay_par;
    logic            meta;

    always_comb begin
        idx_l = '0;
        for (int j = 0; j < 4; j++) begin
            idx_l[j]     = celda_idx(mov_q, k_q, 2'(j));
            linea_ent[j] = matriz_q[idx_l[j][3:2]][idx_l[j][1:0]];
        end
    end

    fusion_linea u_fusion (
        .linea_in  (linea_ent),
        .linea_out (linea_sal),
        .puntos    (puntos),
        .difiere   (difiere)
    );

    // First empty cell scanning upward from lfsr[3:0], wrapping past 15.
    always_comb begin
        libre_enc = 1'b0;
        libre_idx = '0;
        p         = '0;
        for (int i = 0; i < 16; i++) begin
            p = lfsr_q[3:0] + 4'(i);
            if (!libre_enc && matriz_q[p[3:2]][p[1:0]] == '0) begin
                libre_enc = 1'b1;
                libre_idx = p;
            end
        end
        valor_nuevo = (lfsr_q[7:4] == 4'd0) ? 12'd4 : 12'd2;
    end

    always_comb begin
        lleno   = 1'b1;
        hay_par = 1'b0;
        meta    = 1'b0;
        for (int f = 0; f < 4; f++) begin
            for (int c = 0; c < 4; c++) begin
                if (matriz_q[f][c] == '0) lleno = 1'b0;
                if (matriz_q[f][c] >= VALOR_META) meta = 1'b1;
                if (c < 3 && matriz_q[f][c] == matriz_q[f][(c+1)%4]) hay_par = 1'b1;
                if (f < 3 && matriz_q[f][c] == matriz_q[(f+1)%4][c]) hay_par = 1'b1;
            end
        end
    end

    always_comb begin
        estado_d  = estado_q;
        mov_d     = mov_q;
        k_d       = k_q;
        matriz_d  = matriz_q;
        cambio_d  = cambio_q;
        ganado_d  = ganado_q;
        perdido_d = perdido_q;
        lfsr_d    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

        case (estado_q)
            INICIO0, INICIO1: begin
                if (libre_enc) matriz_d[libre_idx[3:2]][libre_idx[1:0]] = valor_nuevo;
                estado_d = (estado_q == INICIO0) ? INICIO1 : IDLE;
            end
            IDLE: begin
                if (mov_valid && mov_ready) begin
                    mov_d    = mov;
                    k_d      = '0;
                    cambio_d = 1'b0;
                    estado_d = LINEA;
                end
            end
            LINEA: begin
                if (mov_valido(mov_q)) begin
                    for (int j = 0; j < 4; j++) begin
                        matriz_d[idx_l[j][3:2]][idx_l[j][1:0]] = linea_sal[j];
                    end
                    cambio_d = cambio_q | difiere;
                end
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) estado_d = NUEVA;
            end
            NUEVA: begin
                if (cambio_q && libre_enc) begin
                    matriz_d[libre_idx[3:2]][libre_idx[1:0]] = valor_nuevo;
                end
                estado_d = EVAL;
            end
            EVAL: begin
                ganado_d  = ganado_q | meta;
                perdido_d = perdido_q | (lleno && !hay_par);
                estado_d  = FIN;
            end
            FIN:     estado_d = IDLE;
            default: estado_d = INICIO0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q  <= INICIO0;
            mov_q     <= '0;
            k_q       <= '0;
            matriz_q  <= '0;
            cambio_q  <= 1'b0;
            ganado_q  <= 1'b0;
            perdido_q <= 1'b0;
            lfsr_q    <= LFSR_SEMILLA;
        end else begin
            estado_q  <= estado_d;
            mov_q     <= mov_d;
            k_q       <= k_d;
            matriz_q  <= matriz_d;
            cambio_q  <= cambio_d;
            ganado_q  <= ganado_d;
            perdido_q <= perdido_d;
            lfsr_q    <= lfsr_d;
        end
    end

`ifdef PUNTAJE_EN
    logic [15:0] puntaje_q, puntaje_d;
    logic [16:0] suma;

    always_comb begin
        suma      = {1'b0, puntaje_q} + 17'(puntos);
        puntaje_d = puntaje_q;
        if (estado_q == LINEA && mov_valido(mov_q)) begin
            puntaje_d = suma[16] ? 16'hFFFF : suma[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) puntaje_q <= '0;
        else     puntaje_q <= puntaje_d;
    end

    assign puntaje = puntaje_q;
`else
    logic [12:0] unused_puntos;
    assign unused_puntos = puntos;
    assign puntaje       = 16'h0000;
`endif

    assign matriz    = matriz_q;
    assign ganado    = ganado_q;
    assign perdido   = perdido_q;
    assign mov_ready = (estado_q == IDLE) && !ganado_q && !perdido_q;
    assign done      = (estado_q == FIN);
    assign cambio    = (estado_q == FIN) && cambio_q;

endmodule

// File: tb/tb_secuenciador_jugada.sv
// Random-play bench for secuenciador_jugada against a move-level 2048 model.
module tb_secuenciador_jugada;

    typedef int lin_t [4];

    localparam logic [15:0] SEM  = 16'hACE1;
    localparam int          META = 64;
    localparam logic [3:0]  IZQ  = 4'b0100;
    localparam logic [3:0]  DER  = 4'b0011;
    localparam logic [3:0]  ARR  = 4'b0101;
    localparam logic [3:0]  ABA  = 4'b0110;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [3:0]            mov = '0;
    logic                  mov_valid = 1'b0;
    logic                  mov_ready, ganado, perdido, done, cambio;
    logic [3:0][3:0][11:0] matriz;
    logic [15:0]           puntaje;

    secuenciador_jugada #(.LFSR_SEMILLA(SEM), .VALOR_META(12'(META))) dut (
        .clk       (clk),
        .rst       (rst),
        .mov       (mov),
        .mov_valid (mov_valid),
        .mov_ready (mov_ready),
        .matriz    (matriz),
        .puntaje   (puntaje),
        .ganado    (ganado),
        .perdido   (perdido),
        .done      (done),
        .cambio    (cambio)
    );

    always #5 clk = ~clk;

    int          bm [4][4];
    int          score;
    bit          gan, per, ch;
    logic [15:0] lfsr;
    bit          e_ready, e_done, e_cambio, chk_en;
    int          pasados = 0;
    int          total   = 0;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    task automatic chk(input string n, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act === exp) pasados++;
        else $display("FAIL %s: got %0h expected %0h", n, act, exp);
    endtask

    function automatic logic [191:0] board_vec();
        logic [191:0] v;
        v = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                v[(r*4+c)*12 +: 12] = 12'(bm[r][c]);
        return v;
    endfunction

    function automatic logic [15:0] exp_score();
`ifdef PUNTAJE_EN
        return 16'(score);
`else
        return 16'h0000;
`endif
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mov_ready", 192'(mov_ready), 192'(e_ready));
            chk("done",      192'(done),      192'(e_done));
            chk("cambio",    192'(cambio),    192'(e_cambio));
            chk("ganado",    192'(ganado),    192'(gan));
            chk("perdido",   192'(perdido),   192'(per));
            chk("puntaje",   192'(puntaje),   192'(exp_score()));
            chk("matriz",    matriz,          board_vec());
        end
    end

    task automatic slide(input lin_t a, output lin_t o, output int pts);
        int q[$];
        int r[$];
        int x;
        pts = 0;
        for (int i = 0; i < 4; i++) if (a[i] != 0) q.push_back(a[i]);
        while (q.size() > 0) begin
            x = q.pop_front();
            if (q.size() > 0 && q[0] == x) begin
                void'(q.pop_front());
                r.push_back(2 * x);
                pts += 2 * x;
            end else begin
                r.push_back(x);
            end
        end
        for (int i = 0; i < 4; i++) o[i] = (i < r.size()) ? r[i] : 0;
    endtask

    task automatic rc(input logic [3:0] code, input int k, input int j, output int r, output int c);
        case (code)
            DER:     begin r = k;     c = 3 - j; end
            ARR:     begin r = j;     c = k;     end
            ABA:     begin r = 3 - j; c = k;     end
            default: begin r = k;     c = j;     end
        endcase
    endtask

    task automatic apply_line(input logic [3:0] code, input int k);
        lin_t a, o;
        int   pts, r, c;
        if (!(code inside {IZQ, DER, ARR, ABA})) return;
        for (int j = 0; j < 4; j++) begin rc(code, k, j, r, c); a[j] = bm[r][c]; end
        slide(a, o, pts);
        for (int j = 0; j < 4; j++) begin
            rc(code, k, j, r, c);
            if (bm[r][c] != o[j]) ch = 1'b1;
            bm[r][c] = o[j];
        end
        score = (score + pts > 65535) ? 65535 : score + pts;
    endtask

    task automatic spawn(input logic [15:0] l);
        int q;
        for (int i = 0; i < 16; i++) begin
            q = (int'(l[3:0]) + i) % 16;
            if (bm[q/4][q%4] == 0) begin
                bm[q/4][q%4] = (l[7:4] == 4'd0) ? 4 : 2;
                return;
            end
        end
    endtask

    task automatic evaluate();
        bit vacio, par;
        vacio = 1'b0;
        par   = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                if (bm[r][c] == 0) vacio = 1'b1;
                if (bm[r][c] >= META) gan = 1'b1;
                if (c < 3 && bm[r][c] == bm[r][c+1]) par = 1'b1;
                if (r < 3 && bm[r][c] == bm[r+1][c]) par = 1'b1;
            end
        if (!vacio && !par) per = 1'b1;
    endtask

    task automatic clear_model();
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) bm[r][c] = 0;
        score = 0; gan = 0; per = 0; ch = 0;
        e_ready = 0; e_done = 0; e_cambio = 0;
    endtask

    // lfsr tracks the DUT generator value during the cycle that follows the edge.
    task automatic step();
        @(posedge clk);
        if (rst) lfsr = SEM;
        else     lfsr = lfsr_next(lfsr);
        #1;
    endtask

    task automatic busy_noise();
        mov_valid = 1'($urandom_range(0, 1));
        mov       = 4'($urandom);
    endtask

    task automatic reset_seq(input int n);
        logic [15:0] l;
        rst = 1'b1;
        mov_valid = 1'b0;
        repeat (n) begin step(); clear_model(); chk_en = 1'b1; end
        rst = 1'b0;
        l = lfsr; step(); spawn(l);
        l = lfsr; step(); spawn(l);
        e_ready = !gan && !per;
    endtask

    task automatic do_move(input logic [3:0] code, input bit abort);
        logic [15:0] l;
        mov = code;
        mov_valid = 1'b1;
        step();
        e_ready = 0;
        ch = 0;
        busy_noise();
        for (int k = 0; k < 4; k++) begin
            step();
            apply_line(code, k);
            busy_noise();
            if (abort && k == 0) begin
                reset_seq(1);
                return;
            end
        end
        l = lfsr;
        step();
        if (ch) spawn(l);
        busy_noise();
        step();
        evaluate();
        e_done = 1'b1;
        e_cambio = ch;
        step();
        e_done = 1'b0;
        e_cambio = 1'b0;
        e_ready = !gan && !per;
        mov_valid = 1'b0;
    endtask

    function automatic logic [47:0] pack_lin(input lin_t o);
        return {12'(o[3]), 12'(o[2]), 12'(o[1]), 12'(o[0])};
    endfunction

    initial begin
        lin_t a, o;
        int   pts, nmov, sel;
        logic [3:0] code;

        chk_en = 1'b0;
        clear_model();

        chk("lfsr_paso", 192'(lfsr_next(16'hACE1)), 192'(16'h5670));
        a = '{2, 2, 2, 2}; slide(a, o, pts);
        chk("fusion_2222", 192'(pack_lin(o)), 192'({12'd0, 12'd0, 12'd4, 12'd4}));
        chk("fusion_2222_pts", 192'(pts), 192'(8));
        a = '{4, 2, 0, 2}; slide(a, o, pts);
        chk("fusion_der_2024", 192'(pack_lin(o)), 192'({12'd0, 12'd0, 12'd4, 12'd4}));
        a = '{2, 4, 8, 16}; slide(a, o, pts);
        chk("fusion_sin_par", 192'(pack_lin(o)), 192'({12'd16, 12'd8, 12'd4, 12'd2}));
        a = '{4, 4, 8, 0}; slide(a, o, pts);
        chk("fusion_una_vez", 192'(pack_lin(o)), 192'({12'd0, 12'd0, 12'd8, 12'd8}));

        reset_seq(3);
        chk("init_matriz", matriz, 192'h002002);
        chk("init_ready", 192'(mov_ready), 192'(1));
        do_move(IZQ, 1'b0);
        chk("mov1_celda00", 192'(matriz[0][0]), 192'(12'd4));
`ifdef PUNTAJE_EN
        chk("mov1_puntaje", 192'(puntaje), 192'(16'd4));
`else
        chk("mov1_puntaje", 192'(puntaje), 192'(16'd0));
`endif

        for (int g = 0; g < 6; g++) begin
            nmov = 0;
            if (g > 0) reset_seq(2);
            while (e_ready && nmov < 250) begin
                repeat ($urandom_range(0, 2)) step();
                sel = $urandom_range(0, 9);
                case (sel)
                    0, 1: code = IZQ;
                    2, 3: code = DER;
                    4, 5: code = ARR;
                    6, 7, 8: code = ABA;
                    default: code = 4'($urandom);
                endcase
                do_move(code, (g == 2 || g == 4) && nmov == 5);
                nmov++;
            end
            if (!e_ready) begin
                mov = IZQ;
                mov_valid = 1'b1;
                repeat (3) step();
                mov_valid = 1'b0;
            end
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pasados, total);
        $finish;
    end

endmodule
